// File: rtl/multi_channel_section_dispatcher_if.sv
// multi_channel_section_dispatcher_if
// Groups the master input word and the per-channel blocking output bus.
// The dispatcher side uses modport 'master' (it owns the offer bus).
// The environment side uses modport 'slave' (it supplies m_in and the sync returns).
interface multi_channel_section_dispatcher_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
);
  logic                     m_in_mode;
  logic [DATA_W-1:0]        m_in_x;
  logic                     m_in_y;
  logic [NUM_CH-1:0]        b_out_mode;
  logic [NUM_CH*DATA_W-1:0] b_out_x;
  logic [NUM_CH-1:0]        b_out_y;
  logic [NUM_CH-1:0]        b_out_notify;
  logic [NUM_CH-1:0]        b_out_sync;

  modport master (
    input  m_in_mode, m_in_x, m_in_y, b_out_sync,
    output b_out_mode, b_out_x, b_out_y, b_out_notify
  );

  modport slave (
    output m_in_mode, m_in_x, m_in_y, b_out_sync,
    input  b_out_mode, b_out_x, b_out_y, b_out_notify
  );
endinterface

// File: rtl/multi_channel_section_dispatcher.sv
// multi_channel_section_dispatcher
// The block alternates between two sections:
//   - offer a stored compound {mode,x,y} on one channel;
//   - sample and transform the master input into the next channel, chosen round-robin.
// Optional feature macro: DSP_TIMEOUT_EN. When it is defined, an offer is abandoned
// after TMO_CYC cycles without sync, and the sticky flag tmo_err is set.
//
// state | meaning
// SEC_A | offer stored compound on cur_ch, wait for sync[cur_ch]
// SEC_B | sample m_in, transform, load and offer the next channel
module multi_channel_section_dispatcher #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int STEP    = 1,
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  multi_channel_section_dispatcher_if.master bus,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch,
  output logic        section_o,
  output logic [15:0] xfer_cnt,
  output logic        tmo_err
);

  localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DATA_W-1:0] STEP_T  = DATA_W'(STEP);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {
    SEC_A = 1'b0,
    SEC_B = 1'b1
  } section_t;

  section_t                 section_q, section_d;
  logic [CH_W-1:0]          cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]          nxt_ch;
  logic [NUM_CH-1:0]        notify_q, notify_d;
  logic [NUM_CH-1:0]        mode_q, mode_d;
  logic [NUM_CH-1:0]        y_q, y_d;
  logic [NUM_CH*DATA_W-1:0] x_q, x_d;
  logic [15:0]              xfer_cnt_q, xfer_cnt_d;
  logic [DATA_W:0]          sum;
  logic [DATA_W-1:0]        res_x;
  logic                     res_y;
  logic                     sync_hit;

`ifdef DSP_TIMEOUT_EN
  localparam int              WAIT_W    = $clog2(TMO_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO_CYC - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              tmo_err_q, tmo_err_d;
`endif

  // Transform of the master word: pass-through for READ, x+STEP with carry into y for WRITE.
  always_comb begin
    sum = {1'b0, bus.m_in_x} + {1'b0, STEP_T};
    if (bus.m_in_mode) begin
      res_x = sum[DATA_W-1:0];
      res_y = sum[DATA_W];
    end else begin
      res_x = bus.m_in_x;
      res_y = bus.m_in_y;
    end
  end

  // Round-robin successor of the current channel; with one channel it stays at 0.
  always_comb begin
    nxt_ch = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_W'(1);
  end

  // In SEC_A notify_q is one-hot on cur_ch, so this masks off sync from every other channel.
  always_comb begin
    sync_hit = |(bus.b_out_sync & notify_q);
  end

  // Next-state logic for the section FSM, the channel registers and the transfer counter.
  always_comb begin
    section_d  = section_q;
    cur_ch_d   = cur_ch_q;
    notify_d   = notify_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    xfer_cnt_d = xfer_cnt_q;
`ifdef DSP_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    tmo_err_d  = tmo_err_q;
`endif
    case (section_q)
      SEC_A: begin
        if (sync_hit) begin
          notify_d   = '0;
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          section_d  = SEC_B;
        end
`ifdef DSP_TIMEOUT_EN
        // A sync arriving on the last wait cycle is served above as a normal transfer.
        else if (wait_cnt_q == WAIT_LAST) begin
          notify_d  = '0;
          tmo_err_d = 1'b1;
          section_d = SEC_B;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end
      SEC_B: begin
        notify_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (CH_W'(i) == nxt_ch) begin
            notify_d[i]                = 1'b1;
            mode_d[i]                  = bus.m_in_mode;
            x_d[i*DATA_W +: DATA_W]    = res_x;
            y_d[i]                     = res_y;
          end
        end
        cur_ch_d  = nxt_ch;
        section_d = SEC_A;
`ifdef DSP_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
    endcase
  end

  // State registers; after reset the all-zero compound is already on offer on channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      section_q  <= SEC_A;
      cur_ch_q   <= '0;
      notify_q   <= NUM_CH'(1);
      mode_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xfer_cnt_q <= '0;
    end else begin
      section_q  <= section_d;
      cur_ch_q   <= cur_ch_d;
      notify_q   <= notify_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

`ifdef DSP_TIMEOUT_EN
  // Wait counter for the current offer and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign tmo_err = tmo_err_q;
`else
  assign tmo_err = 1'b0;
`endif

  assign bus.b_out_mode   = mode_q;
  assign bus.b_out_x      = x_q;
  assign bus.b_out_y      = y_q;
  assign bus.b_out_notify = notify_q;
  assign cur_ch           = cur_ch_q;
  assign section_o        = section_q;
  assign xfer_cnt         = xfer_cnt_q;

endmodule

// File: tb/tb_multi_channel_section_dispatcher.sv
// tb_multi_channel_section_dispatcher
// Directed vector table, hand-written corner sequences, and a randomized run
// checked against a transaction-level reference model.
// The dispatcher is instantiated with NUM_CH=3, DATA_W=32, STEP=1 and TMO_CYC=4.
// Define DSP_TIMEOUT_EN to build and check the timeout feature.
module tb_multi_channel_section_dispatcher;

  localparam int DATA_W  = 32;
  localparam int NUM_CH  = 3;
  localparam int STEP    = 1;
  localparam int TMO_CYC = 4;
`ifdef DSP_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  cur_ch;
  logic        section_o;
  logic [15:0] xfer_cnt;
  logic        tmo_err;

  multi_channel_section_dispatcher_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  multi_channel_section_dispatcher #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .STEP(STEP), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .cur_ch(cur_ch),
    .section_o(section_o), .xfer_cnt(xfer_cnt), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [33:0] ch_fields(int c);
    return {bus.b_out_mode[c], bus.b_out_x[c*DATA_W +: DATA_W], bus.b_out_y[c]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit md, logic [31:0] xi, bit yi, logic [2:0] s);
    rst            = r;
    bus.m_in_mode  = md;
    bus.m_in_x     = xi;
    bus.m_in_y     = yi;
    bus.b_out_sync = s;
  endtask

  // Reference model: one offer at a time, round-robin over channels.
  bit          m_offer;
  int          m_ch;
  int          m_wait;
  int          m_xfer;
  bit          m_tmo;
  bit          m_mode[NUM_CH];
  logic [31:0] m_x[NUM_CH];
  bit          m_y[NUM_CH];

  function automatic void model_reset();
    m_offer = 1'b1;
    m_ch    = 0;
    m_wait  = 0;
    m_xfer  = 0;
    m_tmo   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 1'b0;
      m_x[c]    = 32'h0;
      m_y[c]    = 1'b0;
    end
  endfunction

  function automatic void model_step(bit r, bit md, logic [31:0] xi, bit yi, logic [2:0] s);
    longint unsigned total;
    if (r) begin
      model_reset();
      return;
    end
    if (m_offer) begin
      if (s[m_ch]) begin
        m_xfer  = (m_xfer + 1) % 65536;
        m_offer = 1'b0;
      end else if (TMO_EN) begin
        m_wait++;
        if (m_wait >= TMO_CYC) begin
          m_tmo   = 1'b1;
          m_offer = 1'b0;
        end
      end
    end else begin
      m_ch = (m_ch + 1) % NUM_CH;
      m_mode[m_ch] = md;
      if (md) begin
        total     = longint'(xi) + longint'(STEP);
        m_x[m_ch] = 32'(total % 64'h1_0000_0000);
        m_y[m_ch] = (total >= 64'h1_0000_0000);
      end else begin
        m_x[m_ch] = xi;
        m_y[m_ch] = yi;
      end
      m_offer = 1'b1;
      m_wait  = 0;
    end
  endfunction

  task automatic chk_model();
    logic [2:0]  en;
    logic [2:0]  em;
    logic [2:0]  ey;
    logic [95:0] ex;
    en = m_offer ? 3'(1 << m_ch) : 3'b000;
    for (int c = 0; c < NUM_CH; c++) begin
      em[c]          = m_mode[c];
      ey[c]          = m_y[c];
      ex[c*32 +: 32] = m_x[c];
    end
    chk("rnd_notify",  128'(bus.b_out_notify), 128'(en));
    chk("rnd_cur_ch",  128'(cur_ch),           128'(m_ch));
    chk("rnd_section", 128'(section_o),        128'(!m_offer));
    chk("rnd_xfer",    128'(xfer_cnt),         128'(m_xfer));
    chk("rnd_tmo",     128'(tmo_err),          128'(m_tmo));
    chk("rnd_mode",    128'(bus.b_out_mode),   128'(em));
    chk("rnd_x",       128'(bus.b_out_x),      128'(ex));
    chk("rnd_y",       128'(bus.b_out_y),      128'(ey));
  endtask

  typedef struct {
    bit          rst;
    bit          mode;
    logic [31:0] x;
    bit          y;
    logic [2:0]  sync;
    logic [2:0]  e_notify;
    logic [1:0]  e_ch;
    bit          e_sec;
    logic [15:0] e_xfer;
    int          chk_ch;
    bit          e_mode;
    logic [31:0] e_x;
    bit          e_y;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ncount;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000);

    // Each row: inputs held across one rising edge, expected outputs after it.
    tbl[0]  = '{1, 1, 32'h5,        1, 3'b111, 3'b001, 2'd0, 0, 16'd0, 0, 0, 32'h0,    0};
    tbl[1]  = '{0, 1, 32'h5,        0, 3'b000, 3'b001, 2'd0, 0, 16'd0, 0, 0, 32'h0,    0};
    tbl[2]  = '{0, 1, 32'h5,        0, 3'b001, 3'b000, 2'd0, 1, 16'd1, 0, 0, 32'h0,    0};
    tbl[3]  = '{0, 1, 32'h5,        0, 3'b000, 3'b010, 2'd1, 0, 16'd1, 1, 1, 32'h6,    0};
    tbl[4]  = '{0, 0, 32'h1234,     1, 3'b001, 3'b010, 2'd1, 0, 16'd1, 1, 1, 32'h6,    0};
    tbl[5]  = '{0, 0, 32'h1234,     1, 3'b010, 3'b000, 2'd1, 1, 16'd2, 1, 1, 32'h6,    0};
    tbl[6]  = '{0, 1, 32'hFFFFFFFF, 0, 3'b000, 3'b100, 2'd2, 0, 16'd2, 2, 1, 32'h0,    1};
    tbl[7]  = '{0, 1, 32'hFFFFFFFF, 0, 3'b100, 3'b000, 2'd2, 1, 16'd3, 2, 1, 32'h0,    1};
    tbl[8]  = '{0, 0, 32'h1234,     1, 3'b000, 3'b001, 2'd0, 0, 16'd3, 0, 0, 32'h1234, 1};
    tbl[9]  = '{0, 0, 32'h1234,     1, 3'b001, 3'b000, 2'd0, 1, 16'd4, 0, 0, 32'h1234, 1};
    tbl[10] = '{0, 1, 32'h7,        1, 3'b000, 3'b010, 2'd1, 0, 16'd4, 1, 1, 32'h8,    0};
    tbl[11] = '{0, 1, 32'h7,        1, 3'b000, 3'b010, 2'd1, 0, 16'd4, 2, 1, 32'h0,    1};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].sync);
      tick();
      chk($sformatf("tbl%0d_notify", i), 128'(bus.b_out_notify), 128'(tbl[i].e_notify));
      chk($sformatf("tbl%0d_cur_ch", i), 128'(cur_ch),           128'(tbl[i].e_ch));
      chk($sformatf("tbl%0d_section", i), 128'(section_o),       128'(tbl[i].e_sec));
      chk($sformatf("tbl%0d_xfer", i),   128'(xfer_cnt),         128'(tbl[i].e_xfer));
      chk($sformatf("tbl%0d_tmo", i),    128'(tmo_err),          128'(0));
      chk($sformatf("tbl%0d_fields", i), 128'(ch_fields(tbl[i].chk_ch)),
          128'({tbl[i].e_mode, tbl[i].e_x, tbl[i].e_y}));
    end

    // Throughput: sync held high on all channels, offers rotate ch0,1,2,...
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000);
    tick();
    drive(1'b0, 1'b1, 32'h10, 1'b0, 3'b111);
    ncount = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("tp_notify_phase%0d", k), 128'(bus.b_out_notify != 3'b000), 128'((k % 2) == 0));
      if (bus.b_out_notify != 3'b000) begin
        ncount++;
        chk($sformatf("tp_order%0d", k), 128'(cur_ch), 128'((k / 2) % 3));
      end
    end
    chk("tp_xfer_cnt", 128'(xfer_cnt), 128'(6));
    chk("tp_offer_cnt", 128'(ncount), 128'(6));

    // Reset while channel 1 is on offer with sync low.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000);
    tick();
    drive(1'b0, 1'b1, 32'h5, 1'b1, 3'b001);
    tick();
    drive(1'b0, 1'b1, 32'h5, 1'b1, 3'b000);
    tick();
    tick();
    chk("rm_pre_notify", 128'(bus.b_out_notify), 128'(3'b010));
    chk("rm_pre_fields", 128'(ch_fields(1)), 128'({1'b1, 32'h6, 1'b0}));
    drive(1'b1, 1'b1, 32'h5, 1'b1, 3'b000);
    tick();
    chk("rm_notify", 128'(bus.b_out_notify), 128'(3'b001));
    chk("rm_cur_ch", 128'(cur_ch), 128'(0));
    chk("rm_ch1_fields", 128'(ch_fields(1)), 128'(0));
    chk("rm_xfer", 128'(xfer_cnt), 128'(0));
    chk("rm_tmo", 128'(tmo_err), 128'(0));

`ifdef DSP_TIMEOUT_EN
    // Abandoned offer after TMO_CYC wait cycles.
    drive(1'b0, 1'b0, 32'hAB, 1'b1, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("to_wait%0d_notify", k), 128'(bus.b_out_notify), 128'(3'b001));
    end
    tick();
    chk("to_notify", 128'(bus.b_out_notify), 128'(3'b000));
    chk("to_tmo", 128'(tmo_err), 128'(1));
    chk("to_xfer", 128'(xfer_cnt), 128'(0));
    chk("to_section", 128'(section_o), 128'(1));
    tick();
    chk("to_next_notify", 128'(bus.b_out_notify), 128'(3'b010));
    chk("to_next_fields", 128'(ch_fields(1)), 128'({1'b0, 32'hAB, 1'b1}));
    chk("to_sticky", 128'(tmo_err), 128'(1));
    // Sync on the last wait cycle wins over the timeout.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000);
    tick();
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b001);
    tick();
    chk("tb_edge_xfer", 128'(xfer_cnt), 128'(1));
    chk("tb_edge_tmo", 128'(tmo_err), 128'(0));
    chk("tb_edge_notify", 128'(bus.b_out_notify), 128'(3'b000));
`else
    // Without the timeout the offer waits indefinitely.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 3'b000);
    for (int k = 0; k < 10; k++) tick();
    chk("nt_notify", 128'(bus.b_out_notify), 128'(3'b001));
    chk("nt_section", 128'(section_o), 128'(0));
    chk("nt_tmo", 128'(tmo_err), 128'(0));
`endif

    // Randomized run against the reference model, with occasional resets.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 3'b000);
    model_step(1'b1, 1'b0, 32'h0, 1'b0, 3'b000);
    tick();
    chk_model();
    for (int i = 0; i < 300; i++) begin
      bit          r;
      bit          md;
      logic [31:0] xi;
      bit          yi;
      logic [2:0]  s;
      r  = ($urandom_range(0, 63) == 0);
      md = 1'($urandom_range(0, 1));
      xi = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
      yi = 1'($urandom_range(0, 1));
      s  = 3'($urandom_range(0, 7));
      drive(r, md, xi, yi, s);
      model_step(r, md, xi, yi, s);
      tick();
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
